// File: rtl/sdram_seq_ctrl_pkg.sv
// State codes, command codes and burst-length helper shared by the sequencer and the command encoder.
// Init and work state encodings must stay in step with the encoder's decode tables.
package sdram_seq_ctrl_pkg;

    typedef enum logic [4:0] {
        I_NOP  = 5'd0,
        I_PRE  = 5'd1,
        I_TRP  = 5'd2,
        I_AR   = 5'd3,
        I_TRF  = 5'd4,
        I_MRS  = 5'd5,
        I_TRSC = 5'd6,
        I_DONE = 5'd7
    } init_state_t;

    typedef enum logic [3:0] {
        W_IDLE   = 4'd0,
        W_ACTIVE = 4'd1,
        W_TRCD   = 4'd2,
        W_READ   = 4'd3,
        W_CL     = 4'd4,
        W_RD     = 4'd5,
        W_WRITE  = 4'd6,
        W_WD     = 4'd7,
        W_TWR    = 4'd8,
        W_PRE    = 4'd9,
        W_TRP    = 4'd10,
        W_AR     = 4'd11,
        W_TRFC   = 4'd12
    } work_state_t;

    // {cs_n, ras_n, cas_n, we_n}
    localparam logic [3:0] CMD_NOP   = 4'b0111;
    localparam logic [3:0] CMD_PRGE  = 4'b0010;
    localparam logic [3:0] CMD_A_REF = 4'b0001;
    localparam logic [3:0] CMD_LMR   = 4'b0000;
    localparam logic [3:0] CMD_ACT   = 4'b0011;
    localparam logic [3:0] CMD_READ  = 4'b0101;
    localparam logic [3:0] CMD_WRITE = 4'b0100;

    localparam logic [9:0] CNT_MAX  = 10'd1023;
    localparam logic [9:0] PAGE_LEN = 10'd256;

    // A zero burst still moves one word; anything beyond a page is cut to one page.
    function automatic logic [9:0] eff_burst_len(input logic [9:0] burst);
        if (burst == 10'd0)
            return 10'd1;
        else if (burst > PAGE_LEN)
            return PAGE_LEN;
        else
            return burst;
    endfunction

endpackage

// File: rtl/sdram_ref_timer.sv
// Refresh interval counter: runs while enabled, raises ref_pend_o every REF_PERIOD cycles.
// ref_pend_o stays set until clr_i; a new expiry in the same cycle as clr_i wins.
module sdram_ref_timer #(
    parameter int REF_PERIOD = 781
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic en_i,
    input  logic clr_i,
    output logic ref_pend_o
);
    import sdram_seq_ctrl_pkg::*;

    localparam int CW = $clog2(REF_PERIOD);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          pend_q, pend_d;
    logic          expire;

    always_comb begin
        cnt_d  = cnt_q;
        pend_d = pend_q;
        expire = 1'b0;
        if (en_i) begin
            if (cnt_q == CW'(REF_PERIOD - 1)) begin
                cnt_d  = '0;
                expire = 1'b1;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
        if (expire)
            pend_d = 1'b1;
        else if (clr_i)
            pend_d = 1'b0;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q  <= '0;
            pend_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            pend_q <= pend_d;
        end
    end

    assign ref_pend_o = pend_q;

endmodule

// File: rtl/sdram_seq_ctrl.sv
// SDRAM sequencer: power-up init, then one write/read/refresh at a time; refresh beats bursts.
// Define SDRAM_FAIR_ARB_EN for round-robin read/write ties; otherwise writes win ties.
module sdram_seq_ctrl #(
    parameter int T_POWERUP  = 20000,
    parameter int T_RP       = 4,
    parameter int T_RFC      = 7,
    parameter int T_RSC      = 6,
    parameter int T_RCD      = 2,
    parameter int T_CL       = 3,
    parameter int T_WR       = 2,
    parameter int INIT_AR    = 8,
    parameter int REF_PERIOD = 781
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       sdram_wr_req,
    input  logic       sdram_rd_req,
    input  logic [9:0] sdram_wr_burst,
    input  logic [9:0] sdram_rd_burst,
    output logic [4:0] init_state,
    output logic [3:0] work_state,
    output logic [9:0] cnt_clk,
    output logic       sdram_rd_wr,
    output logic       sdram_init_done,
    output logic       sdram_wr_ack,
    output logic       sdram_rd_ack
);
    import sdram_seq_ctrl_pkg::*;

    init_state_t init_q, init_d;
    work_state_t work_q, work_d;
    logic [9:0]  cnt_q, cnt_d;
    logic [14:0] pu_q, pu_d;
    logic [3:0]  ar_q, ar_d;
    logic        rd_wr_q, rd_wr_d;
    logic [9:0]  len_q, len_d;
    logic        init_done, ref_pend, ref_clr, pick_rd, start_burst;

    assign init_done   = (init_q == I_DONE);
    assign start_burst = (work_q == W_IDLE) && (work_d == W_ACTIVE);
    assign ref_clr     = (work_q == W_IDLE) && (work_d == W_AR);

`ifdef SDRAM_FAIR_ARB_EN
    logic last_rd_q;

    assign pick_rd = sdram_rd_req && (!sdram_wr_req || !last_rd_q);

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            last_rd_q <= 1'b1;
        else if (start_burst)
            last_rd_q <= pick_rd;
    end
`else
    assign pick_rd = sdram_rd_req && !sdram_wr_req;
`endif

    always_comb begin
        init_d  = init_q;
        work_d  = work_q;
        pu_d    = pu_q;
        ar_d    = ar_q;
        rd_wr_d = rd_wr_q;
        len_d   = len_q;

        case (init_q)
            I_NOP: begin
                pu_d = pu_q + 15'd1;
                if (pu_q == 15'(T_POWERUP - 1)) init_d = I_PRE;
            end
            I_PRE:  init_d = I_TRP;
            I_TRP:  if (cnt_q == 10'(T_RP - 1)) init_d = I_AR;
            I_AR: begin
                ar_d   = ar_q + 4'd1;
                init_d = I_TRF;
            end
            I_TRF:  if (cnt_q == 10'(T_RFC - 1)) init_d = (ar_q == 4'(INIT_AR)) ? I_MRS : I_AR;
            I_MRS:  init_d = I_TRSC;
            I_TRSC: if (cnt_q == 10'(T_RSC - 1)) init_d = I_DONE;
            I_DONE: init_d = I_DONE;
            default: init_d = I_NOP;
        endcase

        case (work_q)
            W_IDLE: begin
                if (init_done) begin
                    if (ref_pend) begin
                        work_d = W_AR;
                    end else if (sdram_wr_req || sdram_rd_req) begin
                        work_d  = W_ACTIVE;
                        rd_wr_d = pick_rd;
                        len_d   = eff_burst_len(pick_rd ? sdram_rd_burst : sdram_wr_burst);
                    end
                end
            end
            W_ACTIVE: work_d = W_TRCD;
            W_TRCD:   if (cnt_q == 10'(T_RCD - 1)) work_d = rd_wr_q ? W_READ : W_WRITE;
            W_WRITE:  work_d = (len_q == 10'd1) ? W_TWR : W_WD;
            // W_WRITE already carried the first word, so W_WD runs L-1 cycles.
            W_WD:     if (cnt_q == len_q - 10'd2) work_d = W_TWR;
            W_TWR:    if (cnt_q == 10'(T_WR - 1)) work_d = W_PRE;
            W_READ:   work_d = W_CL;
            W_CL:     if (cnt_q == 10'(T_CL - 1)) work_d = W_RD;
            W_RD:     if (cnt_q == len_q - 10'd1) work_d = W_PRE;
            W_PRE:    work_d = W_TRP;
            W_TRP:    if (cnt_q == 10'(T_RP - 1)) work_d = W_IDLE;
            W_AR:     work_d = W_TRFC;
            W_TRFC:   if (cnt_q == 10'(T_RFC - 1)) work_d = W_IDLE;
            default:  work_d = W_IDLE;
        endcase

        if ((init_d != init_q) || (work_d != work_q))
            cnt_d = 10'd0;
        else if (cnt_q != CNT_MAX)
            cnt_d = cnt_q + 10'd1;
        else
            cnt_d = cnt_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            init_q  <= I_NOP;
            work_q  <= W_IDLE;
            cnt_q   <= 10'd0;
            pu_q    <= 15'd0;
            ar_q    <= 4'd0;
            rd_wr_q <= 1'b0;
            len_q   <= 10'd1;
        end else begin
            init_q  <= init_d;
            work_q  <= work_d;
            cnt_q   <= cnt_d;
            pu_q    <= pu_d;
            ar_q    <= ar_d;
            rd_wr_q <= rd_wr_d;
            len_q   <= len_d;
        end
    end

    sdram_ref_timer #(.REF_PERIOD(REF_PERIOD)) u_ref_timer (
        .clk_i      (clk),
        .rst_i      (rst),
        .en_i       (init_done),
        .clr_i      (ref_clr),
        .ref_pend_o (ref_pend)
    );

    assign init_state      = init_q;
    assign work_state      = work_q;
    assign cnt_clk         = cnt_q;
    assign sdram_rd_wr     = rd_wr_q;
    assign sdram_init_done = init_done;
    assign sdram_wr_ack    = (work_q == W_WRITE) || (work_q == W_WD);
    assign sdram_rd_ack    = (work_q == W_RD);

endmodule
